// File: rtl/up_run_monitor.sv
// Run-control and observation block for the multicycle UP core: sequences IDLE/RUN/HALTED,
// counts cycles and fetches, and detects ebreak, PC stall and timeout. UP_MON_TRACE_EN adds a fetch trace.
module up_run_monitor #(
    parameter int XLEN         = 64,
    parameter int CNT_W        = 32,
    parameter int STALL_CYCLES = 64,
    parameter int TIMEOUT      = 100000,
    parameter int DEPTH        = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     clear,
    input  logic [XLEN-1:0]          pc,
    input  logic [31:0]              instr,
    input  logic                     ir_write,
    input  logic                     reg_write,
    input  logic [4:0]               write_register,
    input  logic [XLEN-1:0]          write_data,
    input  logic [$clog2(DEPTH)-1:0] trace_idx,
    output logic                     running,
    output logic                     halted,
    output logic [1:0]               halt_cause,
    output logic [CNT_W-1:0]         cycle_count,
    output logic [CNT_W-1:0]         instr_count,
    output logic [XLEN-1:0]          x10_value,
    output logic [XLEN-1:0]          trace_pc,
    output logic [31:0]              trace_instr,
    output logic                     trace_valid
);

    localparam int                 IDX_W     = $clog2(DEPTH);
    localparam int                 STALL_W   = $clog2(STALL_CYCLES + 1);
    localparam logic [31:0]        EBREAK    = 32'h0010_0073;
    localparam logic [CNT_W-1:0]   CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]   TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [STALL_W-1:0] STALL_LIM = STALL_W'(STALL_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_HALTED = 2'b10
    } state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    state_e             state_q, state_d;
    logic               running_q, running_d;
    logic               halted_q, halted_d;
    logic [1:0]         cause_q, cause_d;
    logic [CNT_W-1:0]   cycle_q, cycle_d;
    logic [CNT_W-1:0]   instr_q, instr_d;
    logic [XLEN-1:0]    x10_q, x10_d;
    logic [XLEN-1:0]    prev_pc_q, prev_pc_d;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0]   cycle_inc_s;
    logic               ebreak_s;
    logic               trace_wr_s;
    logic               trace_clr_s;

    assign cycle_inc_s = sat_inc(cycle_q);
    assign ebreak_s    = ir_write && (instr == EBREAK);

    // Next-state and accounting logic; ebreak outranks stall, which outranks timeout.
    always_comb begin
        state_d     = state_q;
        cause_d     = cause_q;
        cycle_d     = cycle_q;
        instr_d     = instr_q;
        x10_d       = x10_q;
        prev_pc_d   = prev_pc_q;
        stall_d     = stall_q;
        trace_wr_s  = 1'b0;
        trace_clr_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                prev_pc_d = pc;
                if (clear) begin
                    cycle_d     = '0;
                    instr_d     = '0;
                    stall_d     = '0;
                    trace_clr_s = 1'b1;
                end else begin
                    trace_clr_s = 1'b0;
                end
                if (en) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                prev_pc_d = pc;
                if (clear) begin
                    cycle_d     = '0;
                    instr_d     = '0;
                    stall_d     = '0;
                    trace_clr_s = 1'b1;
                end else begin
                    cycle_d    = cycle_inc_s;
                    instr_d    = ir_write ? sat_inc(instr_q) : instr_q;
                    stall_d    = (pc == prev_pc_q) ? stall_q + STALL_W'(1) : '0;
                    trace_wr_s = ir_write;
                    if (reg_write && (write_register == 5'd10)) begin
                        x10_d = write_data;
                    end else begin
                        x10_d = x10_q;
                    end
                    if (ebreak_s) begin
                        state_d = ST_HALTED;
                        cause_d = 2'b01;
                    end else if (stall_d == STALL_LIM) begin
                        state_d = ST_HALTED;
                        cause_d = 2'b10;
                    end else if (cycle_inc_s == TIMEOUT_C) begin
                        state_d = ST_HALTED;
                        cause_d = 2'b11;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_HALTED: begin
                if (clear) begin
                    state_d     = ST_IDLE;
                    cause_d     = 2'b00;
                    cycle_d     = '0;
                    instr_d     = '0;
                    stall_d     = '0;
                    trace_clr_s = 1'b1;
                end else begin
                    state_d = ST_HALTED;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        running_d = (state_d == ST_RUN);
        halted_d  = (state_d == ST_HALTED);
    end

    // Control and counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            running_q <= 1'b0;
            halted_q  <= 1'b0;
            cause_q   <= 2'b00;
            cycle_q   <= '0;
            instr_q   <= '0;
            x10_q     <= '0;
            prev_pc_q <= '0;
            stall_q   <= '0;
        end else begin
            state_q   <= state_d;
            running_q <= running_d;
            halted_q  <= halted_d;
            cause_q   <= cause_d;
            cycle_q   <= cycle_d;
            instr_q   <= instr_d;
            x10_q     <= x10_d;
            prev_pc_q <= prev_pc_d;
            stall_q   <= stall_d;
        end
    end

    assign running     = running_q;
    assign halted      = halted_q;
    assign halt_cause  = cause_q;
    assign cycle_count = cycle_q;
    assign instr_count = instr_q;
    assign x10_value   = x10_q;

`ifdef UP_MON_TRACE_EN
    logic [XLEN+31:0] mem_q [DEPTH];
    logic [IDX_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [IDX_W:0]   fill_q, fill_d;
    logic [IDX_W-1:0] rd_addr_s;
    logic             rd_valid_s;
    logic [XLEN-1:0]  trace_pc_q, trace_pc_d;
    logic [31:0]      trace_instr_q, trace_instr_d;
    logic             trace_valid_q, trace_valid_d;

    // Index 0 is the newest entry, one slot behind the write pointer.
    assign rd_addr_s  = wr_ptr_q - IDX_W'(1) - trace_idx;
    assign rd_valid_s = ({1'b0, trace_idx} < fill_q);

    // Trace pointer/occupancy update and registered read of the pre-write contents.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        fill_d   = fill_q;
        if (trace_clr_s) begin
            wr_ptr_d = '0;
            fill_d   = '0;
        end else if (trace_wr_s) begin
            wr_ptr_d = wr_ptr_q + IDX_W'(1);
            fill_d   = (fill_q == (IDX_W + 1)'(DEPTH)) ? fill_q : fill_q + (IDX_W + 1)'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
            fill_d   = fill_q;
        end
        if (rd_valid_s) begin
            trace_pc_d    = mem_q[rd_addr_s][XLEN+31:32];
            trace_instr_d = mem_q[rd_addr_s][31:0];
        end else begin
            trace_pc_d    = '0;
            trace_instr_d = '0;
        end
        trace_valid_d = rd_valid_s;
    end

    // Trace storage; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (rst && trace_wr_s) begin
            mem_q[wr_ptr_q] <= {pc, instr};
        end
    end

    // Trace pointer and read-port registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q      <= '0;
            fill_q        <= '0;
            trace_pc_q    <= '0;
            trace_instr_q <= '0;
            trace_valid_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            fill_q        <= fill_d;
            trace_pc_q    <= trace_pc_d;
            trace_instr_q <= trace_instr_d;
            trace_valid_q <= trace_valid_d;
        end
    end

    assign trace_pc    = trace_pc_q;
    assign trace_instr = trace_instr_q;
    assign trace_valid = trace_valid_q;
`else
    logic trace_unused;
    assign trace_unused = ^{trace_idx, trace_wr_s, trace_clr_s};
    assign trace_pc     = '0;
    assign trace_instr  = 32'h0000_0000;
    assign trace_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_up_run_monitor.sv
// Scoreboard bench for up_run_monitor: stimulus queues expected values, a negedge monitor compares them.
module tb_up_run_monitor;

    localparam logic [31:0] EBREAK = 32'h0010_0073;

    logic        clk = 1'b0;
    logic        rst, en, clear, ir_write, reg_write;
    logic [63:0] pc, write_data;
    logic [31:0] instr;
    logic [4:0]  write_register;
    logic [1:0]  trace_idx;
    logic        running, halted, trace_valid;
    logic [1:0]  halt_cause;
    logic [31:0] cycle_count, instr_count, trace_instr;
    logic [63:0] x10_value, trace_pc;

    up_run_monitor #(
        .XLEN(64), .CNT_W(32), .STALL_CYCLES(8), .TIMEOUT(50), .DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .clear(clear), .pc(pc), .instr(instr),
        .ir_write(ir_write), .reg_write(reg_write), .write_register(write_register),
        .write_data(write_data), .trace_idx(trace_idx), .running(running), .halted(halted),
        .halt_cause(halt_cause), .cycle_count(cycle_count), .instr_count(instr_count),
        .x10_value(x10_value), .trace_pc(trace_pc), .trace_instr(trace_instr),
        .trace_valid(trace_valid)
    );

    always #5 clk = ~clk;

    typedef struct { string name; int sel; logic [63:0] exp; } chk_t;
    typedef struct { string name; logic [1:0] cause; logic [31:0] cyc; logic [31:0] ins; } halt_t;

    chk_t  sb_q[$];
    halt_t halt_q[$];
    int    n_vec = 0;
    int    n_err = 0;
    logic  halted_prev = 1'b0;

    function automatic logic [63:0] probe(input int sel);
        case (sel)
            0:       return {63'd0, running};
            1:       return {63'd0, halted};
            2:       return {62'd0, halt_cause};
            3:       return {32'd0, cycle_count};
            4:       return {32'd0, instr_count};
            5:       return x10_value;
            6:       return trace_pc;
            7:       return {32'd0, trace_instr};
            8:       return {63'd0, trace_valid};
            default: return 64'd0;
        endcase
    endfunction

    task automatic push(input string name, input int sel, input logic [63:0] exp);
        chk_t r;
        r.name = name; r.sel = sel; r.exp = exp;
        sb_q.push_back(r);
    endtask

    task automatic push_halt(input string name, input logic [1:0] cause,
                             input logic [31:0] cyc, input logic [31:0] ins);
        halt_t h;
        h.name = name; h.cause = cause; h.cyc = cyc; h.ins = ins;
        halt_q.push_back(h);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: halt events are checked when halted rises; snapshot checks drain every negedge.
    always @(negedge clk) begin
        chk_t        r;
        halt_t       h;
        logic [63:0] act;
        if (halted && !halted_prev) begin
            n_vec++;
            if (halt_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_halt: got cause %0d cycles %0d, expected no halt",
                         halt_cause, cycle_count);
            end else begin
                h = halt_q.pop_front();
                if (halt_cause !== h.cause || cycle_count !== h.cyc || instr_count !== h.ins) begin
                    n_err++;
                    $display("FAIL %s: got cause %0d cycles %0d instrs %0d, expected cause %0d cycles %0d instrs %0d",
                             h.name, halt_cause, cycle_count, instr_count, h.cause, h.cyc, h.ins);
                end
            end
        end
        halted_prev = halted;
        while (sb_q.size() > 0) begin
            r   = sb_q.pop_front();
            act = probe(r.sel);
            n_vec++;
            if (act !== r.exp) begin
                n_err++;
                $display("FAIL %s: got 0x%0h, expected 0x%0h", r.name, act, r.exp);
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; en = 1'b1; clear = 1'b0; ir_write = 1'b0; reg_write = 1'b0;
        pc = 64'd0; instr = 32'd0; write_register = 5'd0; write_data = 64'd0; trace_idx = 2'd0;

        // Reset held with en high
        repeat (3) tick();
        push("rst_running", 0, 64'd0);
        push("rst_halted", 1, 64'd0);
        push("rst_cause", 2, 64'd0);
        push("rst_cycles", 3, 64'd0);
        push("rst_instrs", 4, 64'd0);
        push("rst_x10", 5, 64'd0);
        push("rst_tpc", 6, 64'd0);
        push("rst_tinstr", 7, 64'd0);
        push("rst_tvalid", 8, 64'd0);
        rst = 1'b1;
        tick();
        push("start_running", 0, 64'd1);
        push("start_cycles", 3, 64'd0);
        en = 1'b0;

        // Ebreak on the fifth fetch
        push_halt("ebreak_halt", 2'b01, 32'd5, 32'd5);
        for (int i = 0; i < 5; i++) begin
            pc = 64'h100 + 64'(i * 4);
            instr = (i == 4) ? EBREAK : 32'h0000_0013;
            ir_write = 1'b1;
            tick();
        end
        ir_write = 1'b0; instr = 32'd0;
        for (int i = 0; i < 20; i++) begin
            en = 1'b1; pc = 64'h200 + 64'(i * 4); ir_write = 1'b1;
            reg_write = 1'b1; write_register = 5'd10; write_data = 64'h77;
            tick();
        end
        en = 1'b0; ir_write = 1'b0; reg_write = 1'b0;
        push("hold_halted", 1, 64'd1);
        push("hold_running", 0, 64'd0);
        push("hold_cause", 2, 64'd1);
        push("hold_cycles", 3, 64'd5);
        push("hold_instrs", 4, 64'd5);
        push("hold_x10", 5, 64'd0);

        clear = 1'b1; tick(); clear = 1'b0;
        push("clr1_halted", 1, 64'd0);
        push("clr1_cause", 2, 64'd0);
        push("clr1_instrs", 4, 64'd0);

        // Stall: PC change on cycle 7 restarts the stall count
        pc = 64'h40; en = 1'b1; tick(); en = 1'b0;
        push("stall_running", 0, 64'd1);
        for (int t = 1; t <= 14; t++) begin
            pc = (t >= 7) ? 64'h44 : 64'h40;
            tick();
        end
        push("stall_not_yet", 1, 64'd0);
        push("stall_cycles14", 3, 64'd14);
        push_halt("stall_halt", 2'b10, 32'd15, 32'd0);
        tick();

        // Timeout with a toggling PC
        clear = 1'b1; tick(); clear = 1'b0;
        pc = 64'h200; en = 1'b1; tick(); en = 1'b0;
        for (int t = 1; t <= 49; t++) begin
            pc = (t % 2 == 1) ? 64'h204 : 64'h200;
            tick();
        end
        push("to_not_yet", 1, 64'd0);
        push("to_cycles49", 3, 64'd49);
        push_halt("timeout_halt", 2'b11, 32'd50, 32'd0);
        pc = 64'h200;
        tick();
        pc = 64'h204;
        tick();
        push("to_hold_cycles", 3, 64'd50);
        clear = 1'b1; tick(); clear = 1'b0;
        push("clr2_running", 0, 64'd0);
        push("clr2_halted", 1, 64'd0);
        push("clr2_cause", 2, 64'd0);
        push("clr2_cycles", 3, 64'd0);

        // Priority: ebreak coincides with stall expiry; x10 tracking
        pc = 64'h300; en = 1'b1; tick(); en = 1'b0;
        reg_write = 1'b1; write_register = 5'd10; write_data = 64'hDEAD;
        tick();
        push("x10_write", 5, 64'hDEAD);
        write_register = 5'd11; write_data = 64'hBEEF;
        tick();
        push("x11_ignored", 5, 64'hDEAD);
        reg_write = 1'b0;
        repeat (5) tick();
        push_halt("priority_halt", 2'b01, 32'd8, 32'd1);
        ir_write = 1'b1; instr = EBREAK;
        tick();
        ir_write = 1'b0; instr = 32'd0;
        reg_write = 1'b1; write_register = 5'd10; write_data = 64'h1234;
        tick();
        reg_write = 1'b0;
        push("x10_halted_hold", 5, 64'hDEAD);
        clear = 1'b1; tick(); clear = 1'b0;

        // Trace: six fetches into a four-entry buffer
        pc = 64'h500; en = 1'b1; tick(); en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            pc = 64'(i * 4); instr = 32'h1000_0000 | 32'(i); ir_write = 1'b1;
            tick();
        end
        ir_write = 1'b0;
        push("tr_instrs", 4, 64'd6);
        push("tr_cycles", 3, 64'd6);
`ifdef UP_MON_TRACE_EN
        pc = 64'h600; trace_idx = 2'd0; tick();
        push("tr_idx0_pc", 6, 64'd20);
        push("tr_idx0_instr", 7, 64'h1000_0005);
        push("tr_idx0_valid", 8, 64'd1);
        pc = 64'h604; trace_idx = 2'd3; tick();
        push("tr_idx3_pc", 6, 64'd8);
        push("tr_idx3_instr", 7, 64'h1000_0002);
        push("tr_idx3_valid", 8, 64'd1);
        pc = 64'h608; trace_idx = 2'd1; tick();
        push("tr_idx1_pc", 6, 64'd16);
        pc = 64'h60C; clear = 1'b1; tick(); clear = 1'b0;
        for (int k = 0; k < 4; k++) begin
            pc = 64'h700 + 64'(k * 4); trace_idx = 2'(k);
            tick();
            push("tr_clr_valid", 8, 64'd0);
        end
`else
        pc = 64'h600; trace_idx = 2'd3; tick();
        push("tr_off_pc", 6, 64'd0);
        push("tr_off_instr", 7, 64'd0);
        push("tr_off_valid", 8, 64'd0);
`endif

        // Reset overrides RUN
        pc = 64'h800; rst = 1'b0; tick(); rst = 1'b1;
        push("midrst_running", 0, 64'd0);
        push("midrst_cycles", 3, 64'd0);
        push("midrst_instrs", 4, 64'd0);
        tick();
        tick();
        if (halt_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL halt_missing: %0d expected halt(s) never seen, expected 0 pending", halt_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/up_run_monitor.md
Name: up_run_monitor

Overview:
- Parametrised run-control and observation block for the multicycle UP core.
- Successor to the fixed clock/reset-only simulation harness: sequences a run (idle/run/halted), counts cycles and fetched instructions, and detects end-of-program by ebreak, PC stall or timeout.
- Optionally keeps a circular trace of recent fetches.
- Sits beside UP, fed from the PC, instruction word, IRWrite and register-write observation points. Synthesisable, so it is usable on FPGA as well as in benches.

Parameters:
- XLEN, 64, width of pc and write_data.
- CNT_W, 32, width of cycle_count and instr_count.
- STALL_CYCLES, 64, consecutive unchanged-PC cycles in RUN that declare a stall halt (>=2).
- TIMEOUT, 100000, RUN cycle count at which a timeout halt is declared (< 2^CNT_W).
- DEPTH, 16, trace entries (power of two, >=2); used only with the optional feature.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-low (0 = reset), sampled on clk rising edge
- en  in  1  level; start request while IDLE
- clear  in  1  pulse; returns HALTED to IDLE, zeroes counters and trace occupancy
- pc  in  XLEN  current PC of UP
- instr  in  32  instruction word presented to the IR
- ir_write  in  1  IR load strobe (one fetch)
- reg_write  in  1  register-file write strobe
- write_register  in  5  destination register
- write_data  in  XLEN  register write data
- trace_idx  in  $clog2(DEPTH)  trace read index, 0 = most recent fetch
- running  out  1  state == RUN
- halted  out  1  state == HALTED
- halt_cause  out  2  00 none, 01 ebreak, 10 pc stall, 11 timeout
- cycle_count  out  CNT_W  clocks spent in RUN
- instr_count  out  CNT_W  ir_write strobes seen in RUN
- x10_value  out  XLEN  last value written to x10 (a0) in RUN
- trace_pc  out  XLEN  PC of selected trace entry
- trace_instr  out  32  instruction of selected trace entry
- trace_valid  out  1  selected entry is filled

Behaviour:
- Reset (rst == 0 at an edge):
  - state = IDLE.
  - All outputs 0, including halt_cause = 00 and x10_value = 0.
  - Stall counter, previous-PC register, trace write pointer and fill count all 0.
  - Reset overrides every other input, including mid-RUN.
- FSM:
  - IDLE -> RUN on the edge where en == 1. Counters are not cleared on entry; they accumulate across runs until clear or reset.
  - RUN -> HALTED on the edge where any halt condition holds.
  - HALTED -> IDLE on clear.
  - clear in IDLE or RUN: zeroes counters, stall counter and trace fill/pointer. State is unchanged.
  - en is ignored outside IDLE.
- RUN accounting:
  - cycle_count increments every RUN cycle.
  - instr_count increments on ir_write.
  - Both saturate at all-ones.
  - x10_value updates when reg_write == 1 and write_register == 5'd10; writes to x0 are ignored.
- Halt conditions, evaluated in RUN on registered values. Priority when several fire in the same cycle: ebreak > stall > timeout.
  - ebreak: ir_write == 1 and instr == 32'h00100073. This fetch is counted in instr_count and traced.
  - stall: pc equals the previous-cycle pc for STALL_CYCLES consecutive RUN cycles. Any PC change resets the stall counter to 0.
  - timeout: cycle_count after increment equals TIMEOUT.
- Halt timing: the halt condition is seen at edge N; halted = 1 and halt_cause are valid after edge N. The cycle of edge N is counted in cycle_count; no further counting afterwards.
- HALTED: all counters, halt_cause and x10_value hold until clear or reset. Inputs other than clear and rst are ignored.

Optional Feature:
- Macro: UP_MON_TRACE_EN.
- Defined:
  - DEPTH-entry circular buffer of {pc, instr}, written on each ir_write in RUN.
  - Write pointer wraps modulo DEPTH; fill count saturates at DEPTH.
  - Reads are registered: trace_pc, trace_instr and trace_valid reflect trace_idx one cycle later.
  - trace_valid = (trace_idx < fill). A write and a read in the same cycle return the pre-write ordering.
- Undefined: no storage is instantiated; trace_pc, trace_instr and trace_valid are constant 0.

Test Plan:
- Reset check: hold rst = 0 for 3 clocks with en = 1 -> running = 0, halted = 0, all counters 0. Release rst, en = 1 -> running = 1 after the next edge.
- Ebreak halt: run 5 fetches, the 5th with instr = 32'h00100073 -> halted = 1, halt_cause = 01, instr_count = 5. Values hold for 20 further clocks.
- Stall halt: STALL_CYCLES = 8, pc frozen at 64'h40 -> halt_cause = 10 exactly 8 cycles after the first repeated PC. A PC change at cycle 7 prevents the halt.
- Timeout and clear: TIMEOUT = 50, pc toggling -> halt_cause = 11, cycle_count = 50. Then clear pulse -> IDLE, counters 0.
- Priority and x10: ebreak fetch on the same cycle as a stall expiry -> halt_cause = 01. Earlier reg_write to x10 with 64'hDEAD -> x10_value = 64'hDEAD; a write to x11 leaves it unchanged.
- Trace (UP_MON_TRACE_EN, DEPTH = 4): 6 fetches at PC 0, 4, …, 20 -> idx 0 returns pc 20 and idx 3 returns pc 8, all valid. After clear, trace_valid = 0 for every idx.
